// File: rtl/spread_pkg.sv
// Shared constants for the spreading chipper: default spread factor and code,
// LFSR seed/taps, and the chip-counter width helper.
package spread_pkg;

  localparam int          SPREAD_DEF      = 24;
  localparam logic [23:0] SPREAD_CODE_DEF = 24'hE29B34;

  // Right-shifting Fibonacci LFSR for x^8+x^6+x^5+x^4+1: feedback is the XOR
  // of bits 0,2,3,4 and enters at bit 7; the chip is bit 0.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;

  function automatic int cnt_w(input int s);
    return (s < 2) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/spread_code_gen.sv
// Chip source. Default: fixed CODE pattern, MSB first, indexed by the chip
// counter. With SPREAD_LFSR_EN defined: 8-bit LFSR reseeded on restart and
// stepped per emitted chip; CODE and the index are then unused.
module spread_code_gen
  import spread_pkg::*;
#(
  parameter int                SPREAD = SPREAD_DEF,
  parameter logic [SPREAD-1:0] CODE   = SPREAD_CODE_DEF,
  parameter int                CW     = cnt_w(SPREAD)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          restart_i,
  input  logic          step_i,
  input  logic [CW-1:0] idx_i,
  output logic          chip_o
);

`ifdef SPREAD_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_idx;
  assign unused_idx = &{1'b0, idx_i};

  // Restart has priority so a bit loaded on its predecessor's last chip
  // starts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (restart_i)   lfsr_d = LFSR_SEED;
    else if (step_i) lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
  end

  // LFSR state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign chip_o = lfsr_q[0];
`else
  logic unused_ctl;
  assign unused_ctl = &{1'b0, clk_i, reset_i, restart_i, step_i};
  assign chip_o = CODE[CW'(SPREAD-1) - idx_i];
`endif

endmodule

// File: rtl/spread_chipper.sv
// Direct-sequence spreader: a 1-bit hold buffer feeds a chip engine that emits
// SPREAD registered chips (bit XOR code chip) per input bit, with i_enable
// stalling the chip stream. Optional macro: SPREAD_LFSR_EN selects an LFSR
// chip source instead of CODE.
module spread_chipper
  import spread_pkg::*;
#(
  parameter int                SPREAD = SPREAD_DEF,
  parameter logic [SPREAD-1:0] CODE   = SPREAD_CODE_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_data,
  input  logic i_valid,
  output logic o_ready,
  input  logic i_enable,
  output logic o_data,
  output logic o_valid
);

  localparam int            CW   = cnt_w(SPREAD);
  localparam logic [CW-1:0] LAST = CW'(SPREAD-1);

  logic          buf_bit_q, buf_bit_d, buf_full_q, buf_full_d;
  logic          bit_q, bit_d, act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_data_q, o_data_d, o_valid_q, o_valid_d;
  logic          emit, last, load, accept, chip;

  assign o_ready = ~buf_full_q;
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

  assign emit   = act_q & i_enable;
  assign last   = emit & (cnt_q == LAST);
  assign load   = buf_full_q & (~act_q | last);
  assign accept = i_valid & ~buf_full_q;

  spread_code_gen #(.SPREAD(SPREAD), .CODE(CODE), .CW(CW)) u_code (
    .clk_i     (i_clk),
    .reset_i   (i_reset),
    .restart_i (load),
    .step_i    (emit),
    .idx_i     (cnt_q),
    .chip_o    (chip)
  );

  // Next state for buffer and engine; accept (buffer empty) and load (buffer
  // full) can never coincide, so the buffer updates are exclusive.
  always_comb begin
    buf_bit_d  = buf_bit_q;
    buf_full_d = buf_full_q;
    bit_d      = bit_q;
    act_d      = act_q;
    cnt_d      = cnt_q;
    o_data_d   = o_data_q;
    o_valid_d  = 1'b0;
    if (accept) begin
      buf_bit_d  = i_data;
      buf_full_d = 1'b1;
    end
    if (emit) begin
      o_data_d  = bit_q ^ chip;
      o_valid_d = 1'b1;
      cnt_d     = last ? '0 : cnt_q + 1'b1;
      if (last) act_d = 1'b0;
    end
    if (load) begin
      buf_full_d = 1'b0;
      bit_d      = buf_bit_q;
      act_d      = 1'b1;
      cnt_d      = '0;
    end
  end

  // State registers; reset drops any buffered bit and partial chip sequence.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_bit_q  <= 1'b0;
      buf_full_q <= 1'b0;
      bit_q      <= 1'b0;
      act_q      <= 1'b0;
      cnt_q      <= '0;
      o_data_q   <= 1'b0;
      o_valid_q  <= 1'b0;
    end else begin
      buf_bit_q  <= buf_bit_d;
      buf_full_q <= buf_full_d;
      bit_q      <= bit_d;
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_spread_chipper.sv
// Bench for spread_chipper: a chip-queue model (every accepted bit queues its
// SPREAD expected chips, reset flushes the queue) checked on every cycle, plus
// directed scenarios with literal expected chip words and run lengths.
module tb_spread_chipper;
  localparam int          SPREAD = 24;
  localparam logic [23:0] CODE   = 24'hE29B34;

  logic i_clk = 1'b0, i_reset = 1'b1, i_data = 1'b0, i_valid = 1'b0, i_enable = 1'b1;
  logic o_ready, o_data, o_valid;

  int n_chk = 0, n_fail = 0;

  spread_chipper #(.SPREAD(SPREAD), .CODE(CODE)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_enable(i_enable), .o_data(o_data), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected chip k of a bit b, straight from the chip-source definition.
  function automatic bit model_chip(input bit b, input int k);
`ifdef SPREAD_LFSR_EN
    logic [7:0] s = 8'h01;
    for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    return b ^ s[0];
`else
    return b ^ CODE[SPREAD-1-k];
`endif
  endfunction

  function automatic logic [23:0] model_word(input bit b);
    logic [23:0] w = '0;
    for (int k = 0; k < SPREAD; k++) w[SPREAD-1-k] = model_chip(b, k);
    return w;
  endfunction

  // Chip-queue model and per-cycle checks, plus a log of valid chips/runs.
  bit exp_q[$];
  bit vlog[$];
  int runs[$];
  int cur_run = 0;
  bit s_acc, s_dat, s_en, s_rst, prev_od = 1'b0;

  always @(posedge i_clk) begin
    s_acc = i_valid && o_ready;
    s_dat = i_data;
    s_en  = i_enable;
    s_rst = i_reset;
    #1;
    if (s_rst) begin
      exp_q.delete();
      cur_run = 0;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_ready", o_ready, 1);
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) chk("extra_chip", 1, 0);
        else chk("chip", o_data, exp_q.pop_front());
        vlog.push_back(o_data);
        cur_run++;
      end else if (cur_run > 0) begin
        runs.push_back(cur_run);
        cur_run = 0;
      end
      if (!s_en) begin
        chk("stall_valid", o_valid, 0);
        chk("stall_hold", o_data, prev_od);
      end
      if (s_acc) for (int k = 0; k < SPREAD; k++) exp_q.push_back(model_chip(s_dat, k));
    end
    prev_od = o_data;
  end

  task automatic clear_log();
    vlog.delete();
    runs.delete();
  endtask

  // Present a bit and hold it until accepted; returns at the negedge after
  // the accepting edge, with i_valid still high.
  task automatic send_bit(input bit b);
    int t = 0;
    i_valid = 1'b1;
    i_data  = b;
    while (!o_ready && t < 100) begin @(negedge i_clk); t++; end
    if (t >= 100) chk("send_timeout", 1, 0);
    @(negedge i_clk);
  endtask

  function automatic logic [47:0] log_word(input int n);
    logic [47:0] w = '0;
    for (int i = 0; i < n && i < vlog.size(); i++) w[n-1-i] = vlog[i];
    return w;
  endfunction

  logic [23:0] exp1, exp0;

  initial begin
`ifdef SPREAD_LFSR_EN
    exp1 = model_word(1'b1);
    exp0 = model_word(1'b0);
`else
    exp1 = 24'h1D64CB;
    exp0 = 24'hE29B34;
`endif
    // Reset two cycles, then release.
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_data", o_data, 0);

    // Back-to-back bits 1,0: one 48-chip run.
    clear_log();
    send_bit(1'b1);
    send_bit(1'b0);
    i_valid = 1'b0;
    repeat (60) @(negedge i_clk);
    chk("b2b_runs", runs.size(), 1);
    if (runs.size() > 0) chk("b2b_len", runs[0], 48);
    chk("b2b_chips", log_word(48), {exp1, exp0});

    // Single bit then idle; o_ready back after the load.
    clear_log();
    send_bit(1'b1);
    i_valid = 1'b0;
    chk("ready_full", o_ready, 0);
    @(negedge i_clk);
    chk("ready_after_load", o_ready, 1);
    repeat (40) @(negedge i_clk);
    chk("single_runs", runs.size(), 1);
    if (runs.size() > 0) chk("single_len", runs[0], 24);
    chk("single_chips", log_word(24), {24'h0, exp1});
    chk("single_idle", o_valid, 0);

    // Stall three cycles right after the first chip.
    clear_log();
    send_bit(1'b1);
    i_valid = 1'b0;
    for (int t = 0; t < 20 && !o_valid; t++) @(negedge i_clk);
    i_enable = 1'b0;
    repeat (3) @(negedge i_clk);
    i_enable = 1'b1;
    repeat (40) @(negedge i_clk);
    chk("stall_runs", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("stall_run0", runs[0], 1);
      chk("stall_run1", runs[1], 23);
    end
    chk("stall_chips", log_word(24), {24'h0, exp1});

    // Reset after ten chips; next bit restarts at chip 0.
    clear_log();
    send_bit(1'b0);
    i_valid = 1'b0;
    for (int t = 0; t < 40 && vlog.size() < 10; t++) @(negedge i_clk);
    chk("pre_rst_chips", log_word(10), {38'h0, exp0[23:14]});
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    repeat (5) @(negedge i_clk);
    chk("mid_rst_quiet", o_valid, 0);
    clear_log();
    send_bit(1'b1);
    i_valid = 1'b0;
    repeat (40) @(negedge i_clk);
    chk("rst_next_len", runs.size() > 0 ? runs[0] : 0, 24);
    chk("rst_next_chips", log_word(24), {24'h0, exp1});

    // Randomized traffic with stalls and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      i_valid  = $urandom_range(0, 2) != 0;
      i_data   = $urandom_range(0, 1);
      i_enable = $urandom_range(0, 3) != 0;
      i_reset  = $urandom_range(0, 299) == 0;
      @(negedge i_clk);
    end
    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_enable = 1'b1;
    repeat (80) @(negedge i_clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
